// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - shared opcode, state and datapath-mode types for seq_alu
package seq_alu_pkg;

    // ALU operation codes; encodings 6 and 7 are undefined and yield y = 0
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_OR  = 3'd2,
        OP_AND = 3'd3,
        OP_SLL = 3'd4,
        OP_MUL = 3'd5
    } alu_opcode_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } seq_alu_state_e;

    // Single-step datapath operation
    typedef enum logic {
        ITER_SHIFT = 1'b0,
        ITER_MUL   = 1'b1
    } iter_mode_e;

    localparam int unsigned SEQ_ALU_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/seq_alu_iter.sv
// rtl/seq_alu_iter.sv - combinational single step of the shift / shift-add datapath
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_ALU_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    input  iter_mode_e       mode,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0] mplier_next
);

    // One SLL step (acc <<= 1) or one shift-add multiply step
    always_comb begin
        acc_next    = acc;
        mcand_next  = mcand;
        mplier_next = mplier;
        case (mode)
            ITER_SHIFT: begin
                acc_next = acc << 1;
            end
            ITER_MUL: begin
                if (mplier[0]) begin
                    acc_next = acc + mcand;
                end
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
            end
            default: begin
                acc_next = acc;
            end
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU responder; SEQ_ALU_EARLY_TERM_EN enables early MUL termination
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH      = SEQ_ALU_DEFAULT_WIDTH,
    parameter int unsigned SHAMT_BITS = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  alu_opcode_e      opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             busy
);

    // iter counts completed multiply steps, so it must be able to reach WIDTH-1
    localparam int unsigned ITER_BITS = $clog2(WIDTH) + 1;
    localparam logic [ITER_BITS-1:0]  LAST_ITER = ITER_BITS'(WIDTH - 1);
    localparam logic [ITER_BITS-1:0]  ITER_ONE  = ITER_BITS'(1);
    localparam logic [SHAMT_BITS-1:0] CNT_ONE   = SHAMT_BITS'(1);

    seq_alu_state_e        state_q, state_d;
    logic [WIDTH-1:0]      y_q, y_d;
    logic                  zero_q, zero_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]      mplier_q, mplier_d;
    logic [SHAMT_BITS-1:0] cnt_q, cnt_d;
    logic [ITER_BITS-1:0]  iter_q, iter_d;

    logic [WIDTH-1:0]      acc_nx;
    logic [WIDTH-1:0]      mcand_nx;
    logic [WIDTH-1:0]      mplier_nx;
    iter_mode_e            mode;
    logic                  accept;
    logic                  mul_last;
    logic [WIDTH-1:0]      alu_result;

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign y          = y_q;
    assign zero       = zero_q;
    assign accept     = req_valid && req_ready;
    assign mode       = (state_q == ST_MUL) ? ITER_MUL : ITER_SHIFT;

    seq_alu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .acc         (acc_q),
        .mcand       (mcand_q),
        .mplier      (mplier_q),
        .mode        (mode),
        .acc_next    (acc_nx),
        .mcand_next  (mcand_nx),
        .mplier_next (mplier_nx)
    );

    // Early exit once no multiplier bits remain; otherwise always run every iteration
`ifdef SEQ_ALU_EARLY_TERM_EN
    assign mul_last = (iter_q == LAST_ITER) || (mplier_nx == '0);
`else
    assign mul_last = (iter_q == LAST_ITER);
`endif

    // Single-cycle operations; undefined opcodes produce zero
    always_comb begin
        alu_result = '0;
        case (opcode)
            OP_ADD:  alu_result = a + b;
            OP_SUB:  alu_result = a - b;
            OP_OR:   alu_result = a | b;
            OP_AND:  alu_result = a & b;
            default: alu_result = '0;
        endcase
    end

    // Sequencer next-state, iteration datapath and result capture
    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        zero_d   = zero_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        iter_d   = iter_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_SLL: begin
                            acc_d = a;
                            cnt_d = b[SHAMT_BITS-1:0];
                            if (b[SHAMT_BITS-1:0] == '0) begin
                                state_d = ST_DONE;
                                y_d     = a;
                                zero_d  = (a == '0);
                            end else begin
                                state_d = ST_SHIFT;
                            end
                        end
                        OP_MUL: begin
                            acc_d    = '0;
                            mcand_d  = a;
                            mplier_d = b;
                            iter_d   = '0;
                            state_d  = ST_MUL;
`ifdef SEQ_ALU_EARLY_TERM_EN
                            if (b == '0) begin
                                state_d = ST_DONE;
                                y_d     = '0;
                                zero_d  = 1'b1;
                            end
`endif
                        end
                        default: begin
                            state_d = ST_DONE;
                            y_d     = alu_result;
                            zero_d  = (alu_result == '0);
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                acc_d = acc_nx;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    y_d     = acc_nx;
                    zero_d  = (acc_nx == '0);
                end
            end
            ST_MUL: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_nx;
                mplier_d = mplier_nx;
                iter_d   = iter_q + ITER_ONE;
                if (mul_last) begin
                    state_d = ST_DONE;
                    y_d     = acc_nx;
                    zero_d  = (acc_nx == '0);
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            y_q      <= '0;
            zero_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            iter_q   <= '0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            zero_q   <= zero_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            iter_q   <= iter_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (honours SEQ_ALU_EARLY_TERM_EN)
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    alu_opcode_e   opcode;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          resp_valid;
    logic          resp_ready;
    logic [W-1:0]  y;
    logic          zero;
    logic          busy;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .opcode     (opcode),
        .a          (a),
        .b          (b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .y          (y),
        .zero       (zero),
        .busy       (busy)
    );

    typedef struct {
        alu_opcode_e  op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_y;
        logic         exp_zero;
        int           exp_lat;
        int           hold;
    } vec_t;

    typedef struct {
        logic [W-1:0] y;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference multiply latency: full WIDTH iterations, or up to the top set bit of b
    function automatic int mul_lat(input logic [W-1:0] bv);
        int msb = -1;
        for (int i = 0; i < W; i++) begin
            if (bv[i]) msb = i;
        end
`ifdef SEQ_ALU_EARLY_TERM_EN
        return (msb < 0) ? 1 : msb + 2;
`else
        return (msb >= -1) ? W + 1 : 0;
`endif
    endfunction

    // Issue one request, measure latency, optionally stall, then handshake and score
    task automatic run_op(input string tag, input alu_opcode_e op, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] ey, input logic ez,
                          input int elat, input int hold);
        int   lat;
        exp_t e;
        @(negedge clk);
        check({tag, " req_ready idle"}, {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        opcode    = op;
        a         = av;
        b         = bv;
        sb.push_back('{y: ey, zero: ez});
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        opcode     = OP_ADD;
        a          = $urandom;
        b          = $urandom;
        resp_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 100);
        check({tag, " latency"}, 64'(lat), 64'(elat));
        for (int k = 0; k < hold; k++) begin
            resp_ready = 1'b0;
            req_valid  = 1'b1;
            opcode     = OP_SUB;
            a          = $urandom;
            b          = $urandom;
            @(negedge clk);
            check({tag, " held y"}, {32'd0, y}, {32'd0, ey});
            check({tag, " held resp_valid"}, {63'd0, resp_valid}, 64'd1);
            check({tag, " stall req_ready"}, {63'd0, req_ready}, 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " y"}, {32'd0, y}, {32'd0, e.y});
            check({tag, " zero"}, {63'd0, zero}, {63'd0, e.zero});
        end
        @(negedge clk);
        check({tag, " resp_valid after handshake"}, {63'd0, resp_valid}, 64'd0);
        check({tag, " req_ready after handshake"}, {63'd0, req_ready}, 64'd1);
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stale;
        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        opcode     = OP_ADD;
        a          = '0;
        b          = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset y", {32'd0, y}, 64'd0);
        check("reset zero", {63'd0, zero}, 64'd0);
        check("reset resp_valid", {63'd0, resp_valid}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset req_ready", {63'd0, req_ready}, 64'd1);

        vecs.push_back('{OP_ADD, 32'd124, 32'd17845, 32'd17969, 1'b0, 1, 0});
        vecs.push_back('{OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 0});
        vecs.push_back('{OP_SUB, 32'd156, 32'd156, 32'd0, 1'b1, 1, 0});
        vecs.push_back('{OP_SUB, 32'd15, 32'd7, 32'd8, 1'b0, 1, 0});
        vecs.push_back('{OP_SUB, 32'd7, 32'd15, 32'hFFFF_FFF8, 1'b0, 1, 0});
        vecs.push_back('{OP_OR, 32'd1468, 32'd2861, 32'd4029, 1'b0, 1, 3});
        vecs.push_back('{OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1, 0});
        vecs.push_back('{OP_SLL, 32'd4188, 32'd3, 32'd33504, 1'b0, 4, 0});
        vecs.push_back('{OP_SLL, 32'd4188, 32'd0, 32'd4188, 1'b0, 1, 0});
        vecs.push_back('{OP_SLL, 32'd4188, 32'd35, 32'd33504, 1'b0, 4, 0});
        vecs.push_back('{OP_SLL, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 32, 0});
        vecs.push_back('{OP_SLL, 32'd0, 32'd2, 32'd0, 1'b1, 3, 1});
        vecs.push_back('{OP_MUL, 32'd31, 32'd6, 32'd186, 1'b0, mul_lat(32'd6), 0});
        vecs.push_back('{OP_MUL, 32'hFFFF_FFFB, 32'd7, 32'hFFFF_FFDD, 1'b0, mul_lat(32'd7), 0});
        vecs.push_back('{OP_MUL, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFDD, 1'b0, W + 1, 2});
        vecs.push_back('{OP_MUL, 32'd1234, 32'd0, 32'd0, 1'b1, mul_lat(32'd0), 0});
        vecs.push_back('{OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0,
                         mul_lat(32'h0001_0001), 0});
        vecs.push_back('{OP_MUL, 32'd3, 32'd1, 32'd3, 1'b0, mul_lat(32'd1), 0});
        vecs.push_back('{alu_opcode_e'(3'd7), 32'd5, 32'd9, 32'd0, 1'b1, 1, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_y, vecs[i].exp_zero, vecs[i].exp_lat, vecs[i].hold);
        end

        // Reset in the middle of a long multiply: no response may ever appear
        @(negedge clk);
        req_valid = 1'b1;
        opcode    = OP_MUL;
        a         = 32'd31;
        b         = 32'hFFFF_FFFF;
        sb.push_back('{y: 32'hFFFF_FFE1, zero: 1'b0});
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("mid-mul busy", {63'd0, busy}, 64'd1);
        check("mid-mul resp_valid", {63'd0, resp_valid}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check("abort resp_valid", {63'd0, resp_valid}, 64'd0);
        check("abort y", {32'd0, y}, 64'd0);
        check("abort zero", {63'd0, zero}, 64'd0);
        check("abort req_ready", {63'd0, req_ready}, 64'd1);
        check("abort busy", {63'd0, busy}, 64'd0);
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) stale++;
        end
        check("no stale response", 64'(stale), 64'd0);
        resp_ready = 1'b0;

        run_op("post-reset AND", OP_AND, 32'd15678, 32'd1678, 32'd15678 & 32'd1678, 1'b0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
